// File: rtl/seq_alu.sv
// Multi-cycle arithmetic/shift unit: ADD, SUB, MUL (shift-add), signed DIV/MOD
// (restoring), and bit-serial shifts behind a start/done handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                           OP_MOD = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_SAR = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;       // multiplicand / dividend->quotient / shifted value
    logic [WIDTH-1:0] b_q, b_d;       // multiplier / divisor magnitude / shift amount
    logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;

    logic             is_divmod_in, is_shift_in;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] shifted, q_fix, r_fix;

    assign is_divmod_in = (op == OP_DIV) || (op == OP_MOD);
    assign is_shift_in  = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);

    assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
    assign rem_sh   = {acc_q, a_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    // A zero divisor yields all-ones quotient and the raw dividend as remainder.
    assign q_fix    = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -a_q : a_q);
    assign r_fix    = (b_q == '0) ? orig_q : (sa_q ? -acc_q : acc_q);

    always_comb begin
        shifted = a_q;
        case (op_q)
            OP_SHL:  shifted = a_q << 1;
            OP_SHR:  shifted = a_q >> 1;
            OP_SAR:  shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: shifted = a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        orig_d   = orig_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    orig_d  = in1;
                    sa_d    = in1[WIDTH-1];
                    sb_d    = in2[WIDTH-1];
                    acc_d   = '0;
                    a_d     = (is_divmod_in && in1[WIDTH-1]) ? -in1 : in1;
                    b_d     = (is_divmod_in && in2[WIDTH-1]) ? -in2 : in2;
                    if (is_shift_in)
                        cnt_d = (in2 >= WIDTH'(WIDTH)) ? CW'(WIDTH) : in2[CW-1:0];
                    else
                        cnt_d = CW'(WIDTH);
                end
            end
            S_RUN: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        result_d = (op_q == OP_ADD) ? a_q + b_q : a_q - b_q;
                        dbz_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                    OP_MUL: begin
                        acc_d = mul_sum;
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_d = mul_sum;
                            dbz_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                    end
                    OP_DIV, OP_MOD: begin
                        // Quotient bits shift into a_q as dividend bits shift out.
                        a_d   = {a_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                        acc_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1))
                            state_d = S_FIX;
                    end
                    default: begin
                        if (cnt_q != '0) begin
                            a_d   = shifted;
                            cnt_d = cnt_q - CW'(1);
                        end
                        if (cnt_q <= CW'(1)) begin
                            result_d = (cnt_q == '0) ? a_q : shifted;
                            dbz_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                    end
                endcase
            end
            S_FIX: begin
                result_d = (op_q == OP_DIV) ? q_fix : r_fix;
                dbz_d    = (b_q == '0);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            orig_q   <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            orig_q   <= orig_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): hand-computed results, latencies,
// busy width, result hold, ignored mid-run starts and asynchronous reset.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done, div_by_zero;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_res = '0;
    logic        prev_dbz = 1'b0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; lat is the spec latency (done sampled at edge N+lat).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_z, input int lat,
                          input string tag, input bit pulse);
        int j;
        int busy_n;
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in1 = $urandom; in2 = $urandom; op = 3'($urandom_range(0, 7));
        chk({tag, " result_hold"}, result, prev_res);
        chk({tag, " dbz_hold"}, {31'b0, div_by_zero}, {31'b0, prev_dbz});
        j = 0;
        busy_n = 0;
        while (!done && j < 200) begin
            if (busy) busy_n++;
            if (pulse && j == 3) start = 1'b1;
            if (pulse && j == 4) start = 1'b0;
            @(negedge clk);
            j++;
        end
        if (busy) busy_n++;
        chk({tag, " latency"}, 32'(j + 1), 32'(lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(lat));
        chk({tag, " result"}, result, exp_r);
        chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, exp_z});
        prev_res = exp_r;
        prev_dbz = exp_z;
        @(negedge clk);
        chk({tag, " done_pulse"}, {30'b0, done, busy}, 32'd0);
        chk({tag, " result_after"}, result, exp_r);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
        #1;
        chk("reset_outputs", {28'b0, busy, done, div_by_zero, 1'b0}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd5, 32'd10, 32'd15, 1'b0, 2, "add", 1'b0);
        run_op(3'd1, 32'd5, 32'd10, 32'hFFFFFFFB, 1'b0, 2, "sub", 1'b0);
        run_op(3'd2, 32'd10, 32'd5, 32'd50, 1'b0, 33, "mul", 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33, "mul_neg1_ign", 1'b1);
        run_op(3'd3, 32'd10, 32'hFFFFFFFB, 32'hFFFFFFFE, 1'b0, 34, "div_10_m5", 1'b0);
        run_op(3'd4, 32'd10, 32'd3, 32'd1, 1'b0, 34, "mod_10_3", 1'b0);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34, "mod_m7_2", 1'b0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34, "div_minneg", 1'b0);
        run_op(3'd3, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 34, "div_m100_7", 1'b1);
        run_op(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1'b0, 34, "mod_m100_7", 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b1, 34, "div_by0", 1'b0);
        run_op(3'd4, 32'd7, 32'd0, 32'd7, 1'b1, 34, "mod_by0", 1'b0);
        run_op(3'd0, 32'd1, 32'd2, 32'd3, 1'b0, 2, "add_clr_dbz", 1'b0);
        run_op(3'd5, 32'd1, 32'd6, 32'd64, 1'b0, 7, "shl_1_6", 1'b0);
        run_op(3'd6, 32'd9, 32'd1, 32'd4, 1'b0, 2, "shr_9_1", 1'b0);
        run_op(3'd7, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 2, "sar_ff_1", 1'b0);
        run_op(3'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 1'b0, 2, "sar_fe_1", 1'b0);
        run_op(3'd7, 32'd1, 32'd1, 32'd0, 1'b0, 2, "sar_1_1", 1'b0);
        run_op(3'd5, 32'h12345678, 32'd0, 32'h12345678, 1'b0, 2, "shl_k0", 1'b0);
        run_op(3'd6, 32'h80000000, 32'd100, 32'd0, 1'b0, 33, "shr_big", 1'b0);
        run_op(3'd7, 32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b0, 33, "sar_big", 1'b1);
        run_op(3'd5, 32'h0000F00F, 32'd4, 32'h000F00F0, 1'b0, 5, "shl_4", 1'b0);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        start = 1'b1; op = 3'd2; in1 = 32'd3; in2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        prev_res = '0;
        prev_dbz = 1'b0;
        run_op(3'd0, 32'd5, 32'd10, 32'd15, 1'b0, 2, "add_after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
